// File: rtl/uart_cipher_bridge.sv
// Rolling-key XOR/additive byte cipher between the key/data UART receivers
// and the UART transmitter, with an output FIFO and a start/busy TX handshake.
module uart_cipher_bridge #(
    parameter int KEY_LEN    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          key_valid,
    input  logic [7:0]                    key_data,
    input  logic                          mode,
    input  logic                          decrypt,
    input  logic                          tx_busy,
    output logic                          tx_start,
    output logic [7:0]                    tx_data,
    output logic                          key_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic                          key_err,
    output logic                          active,
    output logic [7:0]                    disp_plain,
    output logic [7:0]                    disp_cipher
);
    localparam int KIW = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int KCW = $clog2(KEY_LEN + 1);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    localparam logic [KCW-1:0] KFULL    = KCW'(KEY_LEN);
    localparam logic [KIW-1:0] KLAST    = KIW'(KEY_LEN - 1);
    localparam logic [CW-1:0]  FULL_CNT = CW'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_HI, WAIT_LO} state_t;

    state_t          state_q, state_d;
    logic [7:0]      key_mem_q [KEY_LEN];
    logic [7:0]      fifo_q [FIFO_DEPTH];
    logic [KCW-1:0]  kcnt_q, kcnt_d;
    logic [KIW-1:0]  kidx_q, kidx_d;
    logic            key_ready_q;
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   fifo_count_q;
    logic            tx_start_q, overflow_q, key_err_q;
    logic [7:0]      tx_data_q, disp_plain_q, disp_cipher_q;

    logic            fifo_full, fifo_empty, accept, pop;
    logic [7:0]      k, c;

    assign fifo_full  = (fifo_count_q == FULL_CNT);
    assign fifo_empty = (fifo_count_q == '0);
    assign accept     = rx_valid && key_ready_q && !key_valid && !fifo_full;
    assign k          = key_mem_q[kidx_q];

    always_comb begin
        c = rx_data ^ k;
        if (mode) begin
            c = decrypt ? (rx_data - k) : (rx_data + k);
        end
    end

    // A key byte arriving on a complete key starts a fresh key at slot 0.
    always_comb begin
        kcnt_d = kcnt_q;
        kidx_d = kidx_q;
        if (key_valid) begin
            if (key_ready_q) begin
                kcnt_d = KCW'(1);
                kidx_d = '0;
            end else begin
                kcnt_d = kcnt_q + 1'b1;
            end
        end else if (accept) begin
            kidx_d = (kidx_q == KLAST) ? '0 : kidx_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty && !tx_busy) begin
                    pop     = 1'b1;
                    state_d = LAUNCH;
                end
            end
            LAUNCH:  state_d = WAIT_HI;
            WAIT_HI: if (tx_busy) state_d = WAIT_LO;
            WAIT_LO: if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (key_valid) begin
            key_mem_q[key_ready_q ? KIW'(0) : KIW'(kcnt_q)] <= key_data;
        end
        if (accept) begin
            fifo_q[wr_ptr_q] <= c;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            kcnt_q        <= '0;
            kidx_q        <= '0;
            key_ready_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            fifo_count_q  <= '0;
            tx_start_q    <= 1'b0;
            tx_data_q     <= '0;
            overflow_q    <= 1'b0;
            key_err_q     <= 1'b0;
            disp_plain_q  <= '0;
            disp_cipher_q <= '0;
        end else begin
            state_q      <= state_d;
            kcnt_q       <= kcnt_d;
            kidx_q       <= kidx_d;
            key_ready_q  <= (kcnt_d == KFULL);
            tx_start_q   <= (state_d == LAUNCH);
            fifo_count_q <= fifo_count_q + CW'(accept) - CW'(pop);
            if (accept) begin
                wr_ptr_q      <= wr_ptr_q + 1'b1;
                disp_plain_q  <= rx_data;
                disp_cipher_q <= c;
            end
            if (pop) begin
                rd_ptr_q  <= rd_ptr_q + 1'b1;
                tx_data_q <= fifo_q[rd_ptr_q];
            end
            if (rx_valid && (!key_ready_q || key_valid)) begin
                key_err_q <= 1'b1;
            end
            if (rx_valid && key_ready_q && !key_valid && fifo_full) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign key_ready   = key_ready_q;
    assign fifo_count  = fifo_count_q;
    assign overflow    = overflow_q;
    assign key_err     = key_err_q;
    assign disp_plain  = disp_plain_q;
    assign disp_cipher = disp_cipher_q;
    assign active      = !fifo_empty || (state_q != IDLE);

endmodule

// File: tb/tb_uart_cipher_bridge.sv
// Scoreboard bench for uart_cipher_bridge with a behavioural UART
// transmitter that answers tx_start with a multi-cycle busy pulse.
module tb_uart_cipher_bridge;
    localparam int KL       = 3;
    localparam int FD       = 4;
    localparam int BUSY_CYC = 6;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid, key_valid, mode, decrypt, tx_busy;
    logic [7:0] rx_data, key_data;
    logic       tx_start, key_ready, overflow, key_err, active;
    logic [7:0] tx_data, disp_plain, disp_cipher;
    logic [2:0] fifo_count;

    always #5 clk = ~clk;

    uart_cipher_bridge #(.KEY_LEN(KL), .FIFO_DEPTH(FD)) dut (
        .clk(clk), .rst(rst),
        .rx_valid(rx_valid), .rx_data(rx_data),
        .key_valid(key_valid), .key_data(key_data),
        .mode(mode), .decrypt(decrypt), .tx_busy(tx_busy),
        .tx_start(tx_start), .tx_data(tx_data),
        .key_ready(key_ready), .fifo_count(fifo_count),
        .overflow(overflow), .key_err(key_err), .active(active),
        .disp_plain(disp_plain), .disp_cipher(disp_cipher)
    );

    int         checks   = 0;
    int         failures = 0;
    logic [7:0] exp_q[$];
    int         kcnt_m    = 0;
    logic       hold_busy = 1'b0;
    int         busy_cnt  = 0;
    int         tx_seen   = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Transmitter model and output scoreboard.
    always @(negedge clk) begin
        logic [7:0] e;
        if (tx_start) begin
            tx_seen++;
            if (exp_q.size() == 0) begin
                check("tx_unexpected", 1, 0);
            end else begin
                e = exp_q.pop_front();
                check("tx_data", tx_data, e);
            end
            busy_cnt = BUSY_CYC;
        end else if (busy_cnt > 0) begin
            busy_cnt--;
        end
        tx_busy = hold_busy || (busy_cnt != 0);
    end

    task automatic send_key(input logic [7:0] kb);
        key_valid = 1'b1;
        key_data  = kb;
        kcnt_m    = (kcnt_m == KL) ? 1 : kcnt_m + 1;
        @(negedge clk);
        key_valid = 1'b0;
    endtask

    task automatic send_rx(input logic [7:0] d, input logic [7:0] c);
        rx_valid = 1'b1;
        rx_data  = d;
        if (kcnt_m == KL && exp_q.size() < FD) exp_q.push_back(c);
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic collide(input logic [7:0] kb, input logic [7:0] d);
        key_valid = 1'b1;
        key_data  = kb;
        rx_valid  = 1'b1;
        rx_data   = d;
        kcnt_m    = (kcnt_m == KL) ? 1 : kcnt_m + 1;
        @(negedge clk);
        key_valid = 1'b0;
        rx_valid  = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || active) && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("drain_done", (n < 300), 1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        kcnt_m = 0;
        exp_q.delete();
    endtask

    initial begin
        int base;
        int n;
        rst = 1'b1; rx_valid = 1'b0; key_valid = 1'b0;
        rx_data = '0; key_data = '0; mode = 1'b0; decrypt = 1'b0;
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 0);
        check("rst_key_ready", key_ready, 0);
        check("rst_fifo_count", fifo_count, 0);
        check("rst_overflow", overflow, 0);
        check("rst_key_err", key_err, 0);
        check("rst_active", active, 0);
        check("rst_disp", {disp_plain, disp_cipher}, 0);
        rst = 1'b0;
        @(negedge clk);

        send_key(8'h11);
        send_key(8'h22);
        check("partial_key_ready", key_ready, 0);
        send_rx(8'h41, 8'h00);
        check("nokey_err", key_err, 1);
        check("nokey_fifo", fifo_count, 0);
        check("nokey_active", active, 0);
        send_key(8'h33);
        check("key_ready", key_ready, 1);
        base = tx_seen;
        send_rx(8'h41, 8'h50);
        send_rx(8'h42, 8'h60);
        send_rx(8'h43, 8'h70);
        send_rx(8'h44, 8'h55);
        wait_drain();
        check("xor_tx_count", tx_seen - base, 4);
        check("xor_disp_plain", disp_plain, 8'h44);
        check("xor_disp_cipher", disp_cipher, 8'h55);

        send_key(8'h11);
        check("rekey_not_ready", key_ready, 0);
        send_key(8'h22);
        send_key(8'h33);
        mode = 1'b1;
        send_rx(8'hF0, 8'h01);
        send_rx(8'h41, 8'h63);
        decrypt = 1'b1;
        send_rx(8'h05, 8'hD2);
        wait_drain();
        check("add_disp_plain", disp_plain, 8'h05);
        check("add_disp_cipher", disp_cipher, 8'hD2);
        mode = 1'b0;
        decrypt = 1'b0;

        do_reset();
        send_key(8'h11);
        send_key(8'h22);
        send_key(8'h33);
        send_rx(8'h10, 8'h01);
        wait_drain();
        check("pre_collide_err", key_err, 0);
        collide(8'hA1, 8'h55);
        check("collide_err", key_err, 1);
        check("collide_fifo", fifo_count, 0);
        check("collide_not_ready", key_ready, 0);
        send_key(8'hB2);
        send_key(8'hC3);
        send_rx(8'h00, 8'hA1);
        send_rx(8'h00, 8'hB2);
        send_rx(8'h00, 8'hC3);
        send_rx(8'h00, 8'hA1);
        wait_drain();
        check("collide_disp", disp_cipher, 8'hA1);

        hold_busy = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("pre_ovf", overflow, 0);
        base = tx_seen;
        send_rx(8'h01, 8'hB3);
        send_rx(8'h02, 8'hC1);
        send_rx(8'h03, 8'hA2);
        send_rx(8'h04, 8'hB6);
        send_rx(8'h05, 8'h00);
        send_rx(8'h06, 8'h00);
        check("ovf_fifo_count", fifo_count, 4);
        check("ovf_flag", overflow, 1);
        check("ovf_no_tx", tx_seen - base, 0);
        hold_busy = 1'b0;
        wait_drain();
        check("ovf_tx_count", tx_seen - base, 4);
        check("ovf_sticky", overflow, 1);

        base = tx_seen;
        send_rx(8'h10, 8'hD3);
        send_rx(8'h20, 8'h81);
        send_rx(8'h30, 8'h82);
        n = 0;
        while (tx_seen == base && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("mid_tx_started", (tx_seen != base), 1);
        repeat (3) @(negedge clk);
        check("mid_fifo", fifo_count, 2);
        check("mid_busy", tx_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        check("mr_fifo", fifo_count, 0);
        check("mr_tx_start", tx_start, 0);
        check("mr_key_ready", key_ready, 0);
        check("mr_overflow", overflow, 0);
        check("mr_active", active, 0);
        rst = 1'b0;
        kcnt_m = 0;
        exp_q.delete();
        base = tx_seen;
        repeat (12) @(negedge clk);
        check("mr_no_tx", tx_seen - base, 0);
        check("mr_idle", active, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/uart_cipher_bridge.md
# uart_cipher_bridge

Parametrised byte-stream cipher engine between the design's UART receivers and UART transmitter. It loads a multi-byte rolling key from the key UART and encrypts or decrypts each data-UART byte with a selectable XOR or additive (mod 256) cipher. Results are buffered in a FIFO that drains into the UART transmitter through a start/busy handshake. Last plaintext and ciphertext bytes are exported for the seven-segment display path.

## Interface
- KEY_LEN, 4: key length in bytes; 1..16.
- FIFO_DEPTH, 8: output FIFO entries; power of two, ≥2.
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- rx_valid  in  1  one-cycle pulse, data byte received.
- rx_data  in  8  data byte, valid with rx_valid.
- key_valid  in  1  one-cycle pulse, key byte received.
- key_data  in  8  key byte, valid with key_valid.
- mode  in  1  0 = XOR, 1 = additive.
- decrypt  in  1  additive mode only: 1 = subtract key.
- tx_busy  in  1  UART transmitter busy.
- tx_start  out  1  one-cycle pulse, launch tx_data.
- tx_data  out  8  byte to transmit; held from tx_start until next pop.
- key_ready  out  1  full key loaded.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- overflow  out  1  sticky: byte dropped because FIFO full.
- key_err  out  1  sticky: byte dropped because key not ready.
- active  out  1  FIFO non-empty or TX FSM not IDLE.
- disp_plain  out  8  last accepted plaintext byte.
- disp_cipher  out  8  last produced cipher byte.

## Operation
- Reset: all outputs 0; key count 0; key index 0; FIFO empty; FSM IDLE. The key memory contents need not be cleared.
- Key load:
  - key_valid writes key_data to key_mem[wr_ptr]; wr_ptr and count increment.
  - key_ready = (count == KEY_LEN).
  - A key_valid arriving while key_ready=1 starts a new key: key_mem[0] is written, count=1, key_ready=0, key index=0.
- Data path:
  - An rx_valid is accepted only if key_ready=1 (registered value), no key_valid is asserted in the same cycle, and the FIFO is not full.
  - Cipher with k = key_mem[kidx]:
    - XOR: c = d ^ k.
    - Additive: c = (d + k) mod 256, or (d − k) mod 256 when decrypt=1.
    - mode and decrypt are sampled in the accept cycle.
  - On accept: push c, set disp_plain=d and disp_cipher=c, then advance kidx, wrapping from KEY_LEN−1 to 0.
  - Rejected because key_ready=0 or key_valid is asserted: set key_err. The byte is dropped and kidx is unchanged.
  - Rejected because the FIFO is full: set overflow. The byte is dropped and kidx is unchanged.
  - Both sticky flags clear only on rst.
- FIFO:
  - Full test uses pre-edge occupancy. An rx byte arriving while full is dropped even if a pop occurs in the same cycle.
  - Simultaneous push and pop with the FIFO not full leaves fifo_count unchanged.
- TX FSM:
  - IDLE: if FIFO non-empty and tx_busy=0, pop the head into tx_data → LAUNCH.
  - LAUNCH: tx_start=1 for this single cycle → WAIT_HI.
  - WAIT_HI: wait for tx_busy=1 → WAIT_LO.
  - WAIT_LO: wait for tx_busy=0 → IDLE.
- rst asserted in any state: return to IDLE; the FIFO is flushed and the in-flight byte abandoned. tx_start is 0 in the cycle after rst.

## Timing
- rx_valid at edge N: FIFO write at edge N; fifo_count updates after edge N.
- IDLE pop at edge N+1 (when the FIFO was empty and tx is idle); tx_start high during cycle N+2; tx_data valid from cycle N+2.
- Minimum spacing between tx_start pulses: 1 LAUNCH + ≥1 WAIT_HI + ≥1 WAIT_LO + 1 IDLE.
- key_valid at edge N: key_ready changes after edge N. An rx_valid in the following cycle uses the new key.
- Outputs are registered, except active, which is combinational from registered state.

## Test plan
- Key load, XOR mode: KEY_LEN=3; load key 0x11, 0x22, 0x33; send 0x41, 0x42, 0x43, 0x44 → tx bytes 0x50, 0x60, 0x70, 0x55 (key wraps); disp_plain=0x44, disp_cipher=0x55.
- Additive mode with wrap: same key, mode=1.
  - Encrypt 0xF0 then 0x41 → 0x01 (0xF0+0x11), then 0x63.
  - decrypt=1, send 0x05 at kidx=2 → 0xD2.
- Key not ready: send 0x41 after 2 of 3 key bytes → no tx_start; key_err=1; fifo_count=0; kidx stays 0 after the key completes.
- Overflow: FIFO_DEPTH=4, tx_busy held 1, send 6 bytes → fifo_count=4, overflow=1; release tx_busy → exactly 4 bytes transmitted in order.
- Re-key and collision:
  - key_valid and rx_valid in the same cycle → rx byte dropped, key_err=1.
  - A new 3-byte key then restarts at kidx 0.
- Reset mid-transfer: assert rst in WAIT_LO with 2 bytes queued → next cycle fifo_count=0, tx_start=0, key_ready=0, overflow=0, FSM IDLE.
